// File: rtl/tile_label.sv
// Tile label generator: converts a 2^exp tile value to decimal, centres the label in its tile,
// and streams glyph code and cell position to the renderer cell by cell.
module tile_label #(
  parameter int CHAR_W = 16,
  parameter int CHAR_H = 32,
  parameter int TILE_W = 100,
  parameter int TILE_H = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] exp,
  input  logic [9:0] tile_x,
  input  logic [9:0] tile_y,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [3:0] char,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic       label_valid,
  output logic       busy
);

  // state  | meaning
  // IDLE   | committed label is being scanned, waiting for load
  // CONV   | double-dabble, one shift-and-add-3 step per clk
  // COMMIT | publish digits, length and placement of the new label
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam int         LG       = $clog2(CHAR_W);
  localparam logic [9:0] POSY_OFF = 10'((TILE_H - CHAR_H) / 2);

  state_t      state, state_nx;
  logic [3:0]  iter_cnt;
  logic [11:0] value;
  logic [15:0] bcd, bcd_adj;
  logic [9:0]  tx_q, ty_q;
  logic        empty_q;
  logic        valid_exp;

  logic [15:0] c_digits;
  logic [2:0]  c_n;
  logic [9:0]  c_start;

  logic [2:0]  n_c;
  logic [9:0]  span_c, start_c;

  logic [9:0]  off, k;
  logic [2:0]  sel;
  logic        hit;
  logic [3:0]  char_c;
  logic [9:0]  posx_c;

  // y only matters for the renderer's vertical windowing
  logic unused_y;
  assign unused_y = ^y;

  assign valid_exp = (exp != 4'd0) && (exp < 4'd12);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (load) begin
      state_nx = valid_exp ? CONV : COMMIT;
    end else begin
      case (state)
        CONV:    if (iter_cnt == 4'd0) state_nx = COMMIT;
        COMMIT:  state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // load has priority so a new request restarts an in-flight conversion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt <= 4'd0;
      value    <= 12'd0;
      bcd      <= 16'd0;
      tx_q     <= 10'd0;
      ty_q     <= 10'd0;
      empty_q  <= 1'b0;
    end else if (load) begin
      iter_cnt <= 4'd11;
      value    <= valid_exp ? (12'd1 << exp) : 12'd0;
      bcd      <= 16'd0;
      tx_q     <= tile_x;
      ty_q     <= tile_y;
      empty_q  <= !valid_exp;
    end else if (state == CONV) begin
      {bcd, value} <= {bcd_adj[14:0], value, 1'b0};
      if (iter_cnt != 4'd0) iter_cnt <= iter_cnt - 4'd1;
    end
  end

  always_comb begin
    n_c = 3'd0;
    if (!empty_q) begin
      if      (bcd[15:12] != 4'd0) n_c = 3'd4;
      else if (bcd[11:8]  != 4'd0) n_c = 3'd3;
      else if (bcd[7:4]   != 4'd0) n_c = 3'd2;
      else if (bcd[3:0]   != 4'd0) n_c = 3'd1;
    end
    span_c  = 10'(TILE_W) - ({7'd0, n_c} << LG);
    start_c = tx_q + (span_c >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_digits    <= 16'd0;
      c_n         <= 3'd0;
      c_start     <= 10'd0;
      posy        <= 10'd0;
      label_valid <= 1'b0;
    end else if (state == COMMIT) begin
      c_digits    <= empty_q ? 16'd0 : bcd;
      c_n         <= n_c;
      c_start     <= start_c;
      posy        <= ty_q + POSY_OFF;
      label_valid <= (n_c != 3'd0);
    end
  end

  // +1 lookahead: the registered output lines up with the beam's current pixel
  always_comb begin
    off    = (x + 10'd1) - c_start;
    k      = off >> LG;
    hit    = label_valid && (k < {7'd0, c_n});
    sel    = c_n - 3'd1 - k[2:0];
    char_c = 4'ha;
    posx_c = c_start;
    if (hit) begin
      char_c = c_digits[{sel[1:0], 2'b00} +: 4];
      posx_c = c_start + (k << LG);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      char <= 4'ha;
      posx <= 10'd0;
    end else begin
      char <= char_c;
      posx <= posx_c;
    end
  end

endmodule

// File: tb/tb_tile_label.sv
// Scoreboard bench for tile_label: stimulus pushes expected outputs per clock,
// a negedge monitor pops and compares them against the DUT.
module tb_tile_label;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] exp;
  logic [9:0] tile_x, tile_y, x, y;
  logic [3:0] char;
  logic [9:0] posx, posy;
  logic       label_valid, busy;

  tile_label dut (
    .clk(clk), .rst(rst), .load(load), .exp(exp),
    .tile_x(tile_x), .tile_y(tile_y), .x(x), .y(y),
    .char(char), .posx(posx), .posy(posy),
    .label_valid(label_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int n;
    int start;
    int posy;
    logic [15:0] dg;   // digit i (most significant first) at dg[4*i +: 4]
  } lab_t;

  typedef struct {
    int    cyc;
    string tag;
    int    ch;
    int    px;
    int    py;
    int    lv;
    int    bz;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  lab_t  cur, prev;
  string tag = "reset";

  function automatic lab_t rst_label();
    lab_t l;
    l.n = 0; l.start = 0; l.posy = 0; l.dg = '0;
    return l;
  endfunction

  function automatic lab_t mk_label(int val, int tx, int ty);
    lab_t l;
    int   v;
    int   tmp[4];
    l.n = 0; l.dg = '0;
    v = val;
    while (v > 0) begin
      tmp[l.n] = v % 10;
      v = v / 10;
      l.n++;
    end
    for (int i = 0; i < l.n; i++) l.dg[4*i +: 4] = 4'(tmp[l.n-1-i]);
    l.start = (tx + (100 - l.n*16) / 2) % 1024;
    l.posy  = (ty + 34) % 1024;
    return l;
  endfunction

  function automatic void scan_model(lab_t l, int b, output int ch, output int px);
    int lo;
    ch = 10;
    px = l.start;
    for (int i = 0; i < l.n; i++) begin
      lo = (l.start + 16*i) % 1024;
      if ((((b - lo) % 1024) + 1024) % 1024 < 16) begin
        ch = l.dg[4*i +: 4];
        px = lo;
      end
    end
  endfunction

  task automatic push(int ch, int px, int py, int lv, int bz);
    exp_t e;
    e.cyc = cyc; e.tag = tag;
    e.ch = ch; e.px = px; e.py = py; e.lv = lv; e.bz = bz;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // scan output after this edge comes from the label committed before it
  task automatic tick_chk(int bz);
    int ch, px;
    tick();
    scan_model(prev, (int'(x) + 1) % 1024, ch, px);
    push(ch, px, cur.posy, (cur.n > 0) ? 1 : 0, bz);
    prev = cur;
  endtask

  task automatic load_tick(int e, int tx, int ty);
    load = 1'b1; exp = 4'(e); tile_x = 10'(tx); tile_y = 10'(ty);
    tick_chk(1);
    load = 1'b0;
  endtask

  task automatic run_conv(int val, int tx, int ty);
    repeat (12) tick_chk(1);
    cur = mk_label(val, tx, ty);
    tick_chk(0);
  endtask

  task automatic scan_range(int lo, int hi);
    for (int b = lo; b <= hi; b++) begin
      x = 10'((b + 1023) % 1024);
      tick_chk(0);
    end
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        failures++;
        $display("FAIL %s stale entry for cyc=%0d seen at cyc=%0d", e.tag, e.cyc, cyc);
      end else if (char !== 4'(e.ch) || posx !== 10'(e.px) || posy !== 10'(e.py) ||
                   label_valid !== 1'(e.lv) || busy !== 1'(e.bz)) begin
        failures++;
        $display("FAIL %s cyc=%0d got char=%h posx=%0d posy=%0d lv=%b busy=%b want char=%h posx=%0d posy=%0d lv=%0d busy=%0d",
                 e.tag, cyc, char, posx, posy, label_valid, busy, 4'(e.ch), e.px, e.py, e.lv, e.bz);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; load = 1'b0; exp = '0; tile_x = '0; tile_y = '0; x = '0; y = '0;
    cur = rst_label(); prev = cur;
    repeat (2) tick();
    rst = 1'b0;
    tick_chk(0);

    // 2048 at (100,50): n=4, start=118, posy=84
    tag = "exp11"; x = 10'd10; y = 10'd60;
    load_tick(11, 100, 50);
    run_conv(2048, 100, 50);
    tick_chk(0);
    scan_range(117, 182);

    // 2 at tile_x=0: start=42
    tag = "exp1";
    load_tick(1, 0, 0);
    run_conv(2, 0, 0);
    scan_range(41, 58);

    // 128: n=3, start=tile_x+26
    tag = "exp7";
    load_tick(7, 300, 200);
    run_conv(128, 300, 200);
    scan_range(325, 375);

    // abort: exp=11 replaced by exp=3 at E5, "128" held meanwhile
    tag = "abort"; x = 10'd330;
    load_tick(11, 400, 100);
    repeat (4) tick_chk(1);
    load_tick(3, 500, 120);
    run_conv(8, 500, 120);
    scan_range(540, 560);

    // reset at E6 of a conversion, then 1024 with 14-cycle latency
    tag = "rst_mid"; x = 10'd545;
    load_tick(10, 700, 700);
    repeat (5) tick_chk(1);
    tick();
    rst = 1'b1;
    cur = rst_label(); prev = cur;
    push(10, 0, 0, 0, 0);
    repeat (2) tick_chk(0);
    rst = 1'b0;
    tick_chk(0);
    tag = "exp10"; x = 10'd217;
    load_tick(10, 200, 300);
    run_conv(1024, 200, 300);
    tick_chk(0);
    scan_range(217, 282);

    // empty and invalid tiles: single busy cycle, blank everywhere
    tag = "exp0"; x = 10'd220;
    load_tick(0, 10, 10);
    cur = mk_label(0, 10, 10);
    tick_chk(0);
    scan_range(0, 120);
    tag = "exp13";
    load_tick(13, 600, 20);
    cur = mk_label(0, 600, 20);
    tick_chk(0);
    scan_range(640, 700);

    repeat (3) tick();
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain %0d expectations never compared", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
